// File: rtl/fetch_decode_latch_pkg.sv
// fetch_decode_latch_pkg: shared NOP encoding and FSM state type for the fetch/decode latch
package fetch_decode_latch_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;
endpackage

// File: rtl/fetch_decode_latch_if.sv
// fetch_decode_latch_if: fetch-side inputs and decode-side outputs of the fetch/decode latch
// master drives PC_f, instruction_f, instrValid_f, stall, flush; sees PC_d, instruction_d, valid_d, fetchStall, bubbleCnt
// slave is the latch itself
interface fetch_decode_latch_if;
  logic [15:0] PC_f;
  logic [15:0] instruction_f;
  logic        instrValid_f;
  logic        stall;
  logic        flush;
  logic [15:0] PC_d;
  logic [15:0] instruction_d;
  logic        valid_d;
  logic        fetchStall;
  logic [15:0] bubbleCnt;
  modport master (
    output PC_f, instruction_f, instrValid_f, stall, flush,
    input  PC_d, instruction_d, valid_d, fetchStall, bubbleCnt
  );
  modport slave (
    input  PC_f, instruction_f, instrValid_f, stall, flush,
    output PC_d, instruction_d, valid_d, fetchStall, bubbleCnt
  );
endinterface

// File: rtl/fetch_decode_latch_reg.sv
// fetch_decode_latch_reg: plain write-enabled register; reset values are muxed in by the caller
// clk: clock, writeEn: load enable, d: next value, q: stored value
module fetch_decode_latch_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             writeEn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (writeEn) q <= d;
endmodule

// File: rtl/fetch_decode_latch.sv
// fetch_decode_latch: IF/ID pipeline register with stall, flush, miss-drop FSM and optional bubble counter
// clk: clock, rst: sync active-high reset, bus: fetch_decode_latch_if.slave (fetch inputs, decode outputs)
// FD_LATCH_BUBBLE_CNT_EN: when defined, bubbleCnt counts saturating bubble loads; otherwise tied to zero
module fetch_decode_latch
  import fetch_decode_latch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fetch_decode_latch_if.slave  bus
);
  state_t      state, state_nx;
  logic        valid_q, valid_nx, take, we;
  logic [15:0] pc_nx, ins_nx;
  // a valid word is only captured in RUN; in DROP it is the stale response to the squashed fetch
  assign take = (state == RUN) & bus.instrValid_f;
  assign we = ~bus.stall | bus.flush | rst;
  always_comb begin
    pc_nx = rst ? 16'h0000 : (bus.flush | take) ? bus.PC_f : bus.PC_d;
    ins_nx = (~rst & ~bus.flush & take) ? bus.instruction_f : NOP_INSTR;
    valid_nx = (rst | bus.flush) ? 1'b0 : bus.stall ? valid_q : take;
    state_nx = rst ? RUN
             : bus.flush ? (bus.instrValid_f ? RUN : DROP)
             : bus.stall ? state
             : (state == DROP & bus.instrValid_f) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    state <= state_nx;
    valid_q <= valid_nx;
  end
  fetch_decode_latch_reg #(.WIDTH(16)) u_pc_reg (
    .clk(clk), .writeEn(we), .d(pc_nx), .q(bus.PC_d)
  );
  fetch_decode_latch_reg #(.WIDTH(16)) u_ins_reg (
    .clk(clk), .writeEn(we), .d(ins_nx), .q(bus.instruction_d)
  );
  assign bus.valid_d = valid_q;
  assign bus.fetchStall = bus.stall & ~bus.flush;
`ifdef FD_LATCH_BUBBLE_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= 16'h0000;
    else if (we & ~valid_nx & ~&cnt) cnt <= cnt + 16'd1;
  assign bus.bubbleCnt = cnt;
`else
  assign bus.bubbleCnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_decode_latch.sv
// tb_fetch_decode_latch: scoreboard bench for fetch_decode_latch
module tb_fetch_decode_latch;
  localparam logic [15:0] NOP = 16'h0800;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
    logic        v;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fetch_decode_latch_if bus();
  fetch_decode_latch dut (.clk(clk), .rst(rst), .bus(bus.slave));
  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_pc, m_ins, m_cnt;
  logic        m_v, m_drop;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] bump(input logic [15:0] c);
`ifdef FD_LATCH_BUBBLE_CNT_EN
    return (c == 16'hFFFF) ? c : c + 16'd1;
`else
    return 16'h0000;
`endif
  endfunction
  task automatic step(input logic r, input logic f, input logic s, input logic iv,
                      input logic [15:0] pc, input logic [15:0] ins);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.flush = f;
    bus.stall = s;
    bus.instrValid_f = iv;
    bus.PC_f = pc;
    bus.instruction_f = ins;
    #1 chk("fetchStall", {31'd0, bus.fetchStall}, {31'd0, s & ~f});
    if (r) begin
      m_pc = 16'h0000; m_ins = NOP; m_v = 1'b0; m_drop = 1'b0; m_cnt = 16'h0000;
    end else if (f) begin
      m_pc = pc; m_ins = NOP; m_v = 1'b0; m_drop = ~iv; m_cnt = bump(m_cnt);
    end else if (s) begin
    end else if (m_drop && iv) begin
      m_ins = NOP; m_v = 1'b0; m_drop = 1'b0; m_cnt = bump(m_cnt);
    end else if (iv) begin
      m_pc = pc; m_ins = ins; m_v = 1'b1;
    end else begin
      m_ins = NOP; m_v = 1'b0; m_cnt = bump(m_cnt);
    end
    sb.push_back('{pc: m_pc, ins: m_ins, v: m_v, cnt: m_cnt});
    @(posedge clk);
    #1;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("PC_d", {16'd0, bus.PC_d}, {16'd0, e.pc});
      chk("instruction_d", {16'd0, bus.instruction_d}, {16'd0, e.ins});
      chk("valid_d", {31'd0, bus.valid_d}, {31'd0, e.v});
      chk("bubbleCnt", {16'd0, bus.bubbleCnt}, {16'd0, e.cnt});
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.instrValid_f = 1'b0;
    bus.PC_f = 16'h0;
    bus.instruction_f = 16'h0;
    step(1, 0, 0, 1, 16'h0040, 16'h1234);
    step(1, 0, 0, 1, 16'h0042, 16'h1234);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 16'h0000, 16'h0000);
    step(0, 0, 0, 1, 16'h0002, 16'hC005);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0004 + 16'(2 * i), 16'h1111);
    step(0, 1, 0, 0, 16'h0010, 16'h0000);
    step(0, 0, 0, 1, 16'h0012, 16'hA111);
    step(0, 0, 0, 1, 16'h0014, 16'hB222);
    step(0, 1, 1, 1, 16'h0020, 16'hCCCC);
    step(0, 0, 0, 1, 16'h0022, 16'hD333);
    step(0, 1, 0, 0, 16'h0030, 16'h0000);
    step(0, 0, 1, 1, 16'h0032, 16'hE444);
    step(0, 0, 0, 1, 16'h0034, 16'hE555);
    step(0, 1, 0, 0, 16'h0040, 16'h0000);
    step(1, 0, 0, 0, 16'h0042, 16'h0000);
    step(0, 0, 0, 1, 16'h0044, 16'hF666);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
`ifdef FD_LATCH_BUBBLE_CNT_EN
    step(1, 0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 16'h0000, 16'h0000);
    step(0, 0, 1, 0, 16'h0000, 16'h0000);
    chk("bubbleCnt_sat", {16'd0, bus.bubbleCnt}, 32'h0000FFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_decode_latch.md
FETCH_DECODE_LATCH -- requirements
Module: fetch_decode_latch

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 PC_f  input  16  incremented PC (PC+2) of the fetched instruction.
REQ-005 instruction_f  input  16  fetched instruction word.
REQ-006 instrValid_f  input  1  instruction memory returned a valid word this cycle.
REQ-007 stall  input  1  hazard unit hold request.
REQ-008 flush  input  1  taken branch/jump redirect; squash fetch-side contents.
REQ-009 PC_d  output  16  registered PC for decode.
REQ-010 instruction_d  output  16  registered instruction for decode; NOP (16'h0800) when bubble.
REQ-011 valid_d  output  1  instruction_d holds a real instruction.
REQ-012 fetchStall  output  1  tells fetch to hold its PC.
REQ-013 bubbleCnt  output  16  bubble counter (see Configuration).

Function
REQ-014 SHALL keep a two-state FSM: RUN, DROP.
REQ-015 Priority each cycle SHALL be rst > flush > stall > DROP-discard > capture > bubble.
REQ-016 flush SHALL load instruction_d=16'h0800, valid_d=0 and PC_d=PC_f next cycle.
REQ-017 flush with instrValid_f=0 SHALL enter DROP; flush with instrValid_f=1 SHALL stay in or return to RUN.
REQ-018 stall without flush SHALL hold PC_d, instruction_d, valid_d and FSM state unchanged.
REQ-019 In DROP, instrValid_f=1 without flush or stall SHALL discard the word (bubble) and return to RUN.
REQ-020 In RUN, instrValid_f=1 without flush or stall SHALL capture PC_f and instruction_f with valid_d=1, one-cycle latency.
REQ-021 In RUN or DROP, instrValid_f=0 without flush or stall SHALL load a bubble (NOP, valid_d=0) and hold PC_d.
REQ-022 fetchStall SHALL be combinational: stall & ~flush.
REQ-023 Simultaneous stall and flush SHALL be treated as flush only.

Reset
REQ-024 rst SHALL force PC_d=16'h0000, instruction_d=16'h0800, valid_d=0 and state=RUN next edge, overriding all inputs.
REQ-025 rst in DROP SHALL cancel the pending discard.
REQ-026 rst SHALL clear bubbleCnt to 16'h0000.

Configuration
REQ-027 Macro FD_LATCH_BUBBLE_CNT_EN SHALL gate the bubble counter.
REQ-028 When defined, bubbleCnt SHALL increment by 1 on each non-reset edge that loads valid_d=0, saturate at 16'hFFFF, and hold during stall.
REQ-029 When undefined, bubbleCnt SHALL be tied to 16'h0000 and no counter flops SHALL be instantiated.

Structure
REQ-030 Shared package SHALL hold the NOP_INSTR constant (16'h0800) and the FSM state encoding (RUN=0, DROP=1).
REQ-031 PC_d and instruction_d storage SHALL use the existing register sub-module: width 16, writeEn=~stall|flush|rst.
REQ-032 FSM, valid_d and counter SHALL live in this module; target 120-250 RTL lines.

Verification
REQ-033 Reset: rst=1 with instrValid_f=1 and instruction_f=16'h1234 -> next cycle PC_d=0000, instruction_d=0800, valid_d=0, bubbleCnt=0.
REQ-034 Capture: PC_f=0002, instruction_f=C005, instrValid_f=1 -> next cycle PC_d=0002, instruction_d=C005, valid_d=1.
REQ-035 Stall: after REQ-034, stall=1 for 3 cycles with new fetch inputs -> outputs hold 0002/C005/1 and fetchStall=1 each cycle.
REQ-036 Flush on miss: flush=1 with instrValid_f=0, then instrValid_f=1 with instruction_f=A111 -> two bubbles (0800, valid 0); next valid word captured with valid_d=1.
REQ-037 Stall+flush: stall=1 and flush=1 together -> fetchStall=0; next cycle instruction_d=0800, valid_d=0.
REQ-038 Counter (macro defined): 5 bubble cycles from reset -> bubbleCnt=5; preload to FFFE and force 3 bubbles -> bubbleCnt=FFFF (saturated); macro undefined -> bubbleCnt=0 throughout.
